// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters, feeding a
// single-entry output register (skid-free: reloads on the same edge it drains).
module rr_mux_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  output logic [3:0]       req_ready,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  // The state bit is the output valid flag itself.
  assign out_valid = (state == FULL);

  // First valid requester searching upward from ptr, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign can_accept = rst_n && ((state == EMPTY) || out_ready);
  assign req_ready  = (can_accept && found) ? (4'b0001 << win) : '0;
  assign xfer       = |(req_valid & req_ready);

  always_comb begin
    mux_data = d0;
    case (win)
      2'd0: mux_data = d0;
      2'd1: mux_data = d1;
      2'd2: mux_data = d2;
      2'd3: mux_data = d3;
      default: mux_data = d0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (xfer)
      state_nxt = FULL;
    else if ((state == FULL) && out_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      sel <= '0;
      ptr <= '0;
    end else if (xfer) begin
      y   <= mux_data;
      sel <= win;
      ptr <= win + 2'd1;
    end
  end

endmodule
